// File: rtl/alu_rr_scheduler.sv
// ============================================================================
// Module   : alu_rr_scheduler
// Brief    : Round-robin arbiter sharing one combinational ALU between
//            NUM_REQ requesters, with a valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int RW      = 16,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [4*NUM_REQ-1:0]  req_sel,
    input  logic [DW*NUM_REQ-1:0] req_in1,
    input  logic [DW*NUM_REQ-1:0] req_in2,
    output logic [3:0]            alu_sel,
    output logic [DW-1:0]         alu_in1,
    output logic [DW-1:0]         alu_in2,
    input  logic [RW-1:0]         alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [RW-1:0]         rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [3:0]         r_alu_sel;
    logic [DW-1:0]      r_alu_in1;
    logic [DW-1:0]      r_alu_in2;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [RW-1:0]      r_rsp_data;
    logic               r_rsp_err;

    logic               w_found;
    logic [IDW-1:0]     w_grant;
    logic [3:0]         w_sel;
    logic [DW-1:0]      w_in1;
    logic [DW-1:0]      w_in2;
    logic [IDW-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_err;

    // Rotating priority: indices at or above rr_ptr first, then the wrapped-around low ones.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sel   = '0;
        w_in1   = '0;
        w_in2   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (i >= int'(r_rr_ptr))) begin
                w_found = 1'b1;
                w_grant = IDW'(i);
                w_sel   = req_sel[4*i +: 4];
                w_in1   = req_in1[DW*i +: DW];
                w_in2   = req_in2[DW*i +: DW];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (i < int'(r_rr_ptr))) begin
                w_found = 1'b1;
                w_grant = IDW'(i);
                w_sel   = req_sel[4*i +: 4];
                w_in1   = req_in1[DW*i +: DW];
                w_in2   = req_in2[DW*i +: DW];
            end
        end
    end

    // Ready is suppressed while reset is held so nothing looks accepted during reset.
    always_comb begin
        w_req_ready = '0;
        if (rst_n && (r_state == c_IDLE) && w_found) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    assign w_next_ptr = (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
    assign w_err      = (r_alu_sel >= 4'hD) || ((r_alu_sel == 4'h3) && (r_alu_in2 == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_rr_ptr    <= '0;
            r_alu_sel   <= '0;
            r_alu_in1   <= '0;
            r_alu_in2   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_alu_sel <= w_sel;
                        r_alu_in1 <= w_in1;
                        r_alu_in2 <= w_in2;
                        r_rsp_id  <= w_grant;
                        r_rr_ptr  <= w_next_ptr;
                        r_state   <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_rsp_data  <= alu_out;
                    r_rsp_err   <= w_err;
                    r_rsp_valid <= 1'b1;
                    r_state     <= c_RESP;
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign alu_sel   = r_alu_sel;
    assign alu_in1   = r_alu_in1;
    assign alu_in2   = r_alu_in2;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != c_IDLE);

endmodule

`default_nettype wire
